// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the register-file read ports, control and the HI/LO unit.
interface hilo_muldiv_if;
  localparam int unsigned W = 32;

  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;

  modport master (
    output start, op, rs_data, rt_data, mthi, mtlo,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, rs_data, rt_data, mthi, mtlo,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module hilo_muldiv (
  input  logic            clk,
  input  logic            reset,
  hilo_muldiv_if.slave    bus
);
  localparam int unsigned W    = 32;
  localparam int unsigned W2   = 2 * W;
  localparam int unsigned CW   = 5;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W2-1:0]  acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;
  logic           sa_q, sa_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           signed_op;
  logic [W-1:0]   a_abs, b_abs;
  logic [W:0]     mul_sum;
  logic [W:0]     div_trial;
  logic [W2-1:0]  prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;

  // Signed ops work on magnitudes; signs are re-applied in FIX.
  assign signed_op = ~bus.op[0];
  assign a_abs     = (signed_op && bus.rs_data[W-1]) ? -bus.rs_data : bus.rs_data;
  assign b_abs     = (signed_op && bus.rt_data[W-1]) ? -bus.rt_data : bus.rt_data;

  // Shift-add step: add multiplicand to upper half when the multiplier LSB is set.
  assign mul_sum   = {1'b0, acc_q[W2-1:W]} + {1'b0, (acc_q[0] ? a_q : '0)};
  // Restoring step: trial subtract of divisor from {remainder, next dividend bit}.
  assign div_trial = {acc_q[W2-1:W], acc_q[W-1]} - {1'b0, b_q};

  assign prod_fix  = neg_q ? -acc_q : acc_q;
  assign quo_fix   = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem_fix   = sa_q ? -acc_q[W2-1:W] : acc_q[W2-1:W];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    sa_d    = sa_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          a_d     = a_abs;
          b_d     = b_abs;
          sa_d    = signed_op & bus.rs_data[W-1];
          neg_d   = signed_op & (bus.rs_data[W-1] ^ bus.rt_data[W-1]);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
          acc_d   = {{W{1'b0}}, (bus.op[1] ? a_abs : b_abs)};
`ifdef MULDIV_FAST_MUL_EN
          if (!bus.op[1]) begin
            acc_d   = W2'(a_abs) * W2'(b_abs);
            state_d = FIX;
          end
`endif
        end else begin
          if (bus.mthi) hi_d = bus.rs_data;
          if (bus.mtlo) lo_d = bus.rs_data;
        end
      end

      CALC: begin
        if (op_q[1]) begin
          acc_d = div_trial[W] ? {acc_q[W2-2:0], 1'b0}
                               : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIX;
      end

      FIX: begin
        if (op_q[1]) begin
          // Divide by zero: no trap, HI returns the original dividend.
          if (b_q == '0) begin
            lo_d = '1;
            hi_d = sa_q ? -a_q : a_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
          hi_d = prod_fix[W2-1:W];
          lo_d = prod_fix[W-1:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      sa_q    <= sa_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed scoreboard bench for hilo_muldiv: expected {HI,LO} queued at issue, checked at done.
module tb_hilo_muldiv;
  localparam int unsigned W = 32;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   e0     = 0;
  logic [63:0] exp_q[$];

  hilo_muldiv_if bus ();

  hilo_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input string tag);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
    exp_q.push_back({ehi, elo});
    @(posedge clk);
    #1;
    e0 = cyc;
    bus.start   = 1'b0;
    bus.rs_data = '0;
    bus.rt_data = '0;
    check({tag, " busy_after_start"}, 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_result(input int exp_lat, input string tag);
    int n;
    logic [63:0] exp;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " done_seen"}, 64'(bus.done), 64'd1);
    check({tag, " latency"}, 64'(cyc - e0), 64'(exp_lat));
    check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
    check({tag, " scoreboard_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    check({tag, " hi"}, 64'(bus.hi), 64'(exp[63:32]));
    check({tag, " lo"}, 64'(bus.lo), 64'(exp[31:0]));
    @(posedge clk);
    #1;
    check({tag, " done_pulse_end"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.op      = '0;
    bus.rs_data = '0;
    bus.rt_data = '0;
    bus.mthi    = 1'b0;
    bus.mtlo    = 1'b0;
    reset       = 1'b1;
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // MTHI and MTLO together
    @(negedge clk);
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    bus.rs_data = 32'h12345678;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    check("mthi hi", 64'(bus.hi), 64'h12345678);
    check("mtlo lo", 64'(bus.lo), 64'h12345678);
    check("mt no busy", 64'(bus.busy), 64'd0);

    start_op(OP_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult");
    wait_result(MUL_LAT, "mult");
    start_op(OP_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, "multu");
    wait_result(MUL_LAT, "multu");
    start_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    wait_result(DIV_LAT, "div_neg");
    start_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu");
    wait_result(DIV_LAT, "divu");
    start_op(OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, "divu_by0");
    wait_result(DIV_LAT, "divu_by0");
    start_op(OP_DIV, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF, "div_by0_neg");
    wait_result(DIV_LAT, "div_by0_neg");
    start_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, "div_ovf");
    wait_result(DIV_LAT, "div_ovf");
    start_op(OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min");
    wait_result(MUL_LAT, "mult_min");

    // MTHI/MTLO/start while busy must be ignored
    start_op(OP_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, "div_busy_poke");
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.mthi    = 1'b1;
    bus.mtlo    = 1'b1;
    bus.start   = 1'b1;
    bus.op      = OP_MULTU;
    bus.rs_data = 32'hDEADBEEF;
    bus.rt_data = 32'd9;
    @(posedge clk);
    #1;
    bus.mthi    = 1'b0;
    bus.mtlo    = 1'b0;
    bus.start   = 1'b0;
    bus.rs_data = '0;
    bus.rt_data = '0;
    check("poke busy_kept", 64'(bus.busy), 64'd1);
    wait_result(DIV_LAT, "div_busy_poke");

    // Asynchronous reset in the middle of a divide
    start_op(OP_DIV, 32'd1000, 32'd3, 32'd1, 32'd333, "div_reset");
    repeat (14) @(posedge clk);
    #1;
    check("pre_reset busy", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    #1;
    void'(exp_q.pop_back());
    check("mid_reset hi", 64'(bus.hi), 64'd0);
    check("mid_reset lo", 64'(bus.lo), 64'd0);
    check("mid_reset busy", 64'(bus.busy), 64'd0);
    check("mid_reset done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    start_op(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, "multu_after_reset");
    wait_result(MUL_LAT, "multu_after_reset");

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
